// File: rtl/alu_writeback_buffer.sv
// Two-entry skid buffer between the function unit and register-file writeback.
// Optional status register enabled by defining STATUS_REG_EN.
module alu_writeback_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] Result,
  input  logic                  Overflow,
  input  logic                  CarryOut,
  input  logic                  Negative,
  input  logic                  Zero,
  input  logic                  trap_ovf,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  reg_write,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [3:0]            out_flags,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_reg_write,
  output logic                  out_exc
`ifdef STATUS_REG_EN
  ,
  input  logic                  status_clr,
  output logic [4:0]            status
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [3:0]            flags;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  exc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t r_state, w_state_next;
  entry_t r_head, r_tail, w_head_next, w_tail_next, w_in_entry;
  logic   w_accept, w_deliver, w_exc;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  // Trapped overflow and writes to r0 never reach the register file.
  assign w_exc = trap_ovf & Overflow;
  always_comb begin
    w_in_entry.result    = Result;
    w_in_entry.flags     = {Overflow, CarryOut, Negative, Zero};
    w_in_entry.dest      = dest_reg;
    w_in_entry.reg_write = reg_write & ~w_exc & (dest_reg != '0);
    w_in_entry.exc       = w_exc;
  end

  always_comb begin
    w_state_next = r_state;
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_head_next  = w_in_entry;
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (w_accept && !w_deliver) begin
          w_tail_next  = w_in_entry;
          w_state_next = FULL;
        end else if (!w_accept && w_deliver) begin
          w_state_next = EMPTY;
        end else if (w_accept && w_deliver) begin
          w_head_next  = w_in_entry;
        end
      end
      FULL: begin
        if (w_deliver) begin
          w_head_next  = r_tail;
          w_state_next = ONE;
        end
      end
      default: w_state_next = EMPTY;
    endcase
    // A same-cycle accept is dropped; a same-cycle deliver already happened downstream.
    if (flush) w_state_next = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_next;
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
    end
  end

  assign out_result    = r_head.result;
  assign out_flags     = r_head.flags;
  assign out_dest      = r_head.dest;
  assign out_reg_write = r_head.reg_write;
  assign out_exc       = r_head.exc;

`ifdef STATUS_REG_EN
  logic [4:0] r_status;
  logic       w_sticky_next;

  // Sticky set from a delivered exception wins over a same-cycle clear.
  assign w_sticky_next = (r_status[4] & ~status_clr) | (w_deliver & r_head.exc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= '0;
    end else begin
      r_status[4] <= w_sticky_next;
      if (w_deliver) begin
        r_status[3:0] <= {r_head.flags[2:0], 1'b1};
      end else if (status_clr) begin
        r_status[3:0] <= '0;
      end
    end
  end

  assign status = r_status;
`endif

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Self-checking bench for alu_writeback_buffer: directed scenarios plus a
// randomized run against a queue-based model. Define STATUS_REG_EN to cover status.
module tb_alu_writeback_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] Result;
  logic        Overflow, CarryOut, Negative, Zero, trap_ovf;
  logic [4:0]  dest_reg;
  logic        reg_write, out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_exc;
`ifdef STATUS_REG_EN
  logic        status_clr;
  logic [4:0]  status;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [4:0]  dest;
    logic        rw;
    logic        exc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_writeback_buffer #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut),
    .Negative(Negative), .Zero(Zero), .trap_ovf(trap_ovf),
    .dest_reg(dest_reg), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .out_exc(out_exc)
`ifdef STATUS_REG_EN
    , .status_clr(status_clr), .status(status)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] res, input logic ovf, input logic co,
                       input logic neg, input logic z, input logic trap,
                       input logic [4:0] dst, input logic rw);
    in_valid = v; Result = res; Overflow = ovf; CarryOut = co; Negative = neg; Zero = z;
    trap_ovf = trap; dest_reg = dst; reg_write = rw;
  endtask

  // Expected captured entry, derived from the writeback rules.
  function automatic exp_t make_exp(input logic [31:0] res, input logic ovf, input logic co,
                                    input logic neg, input logic z, input logic trap,
                                    input logic [4:0] dst, input logic rw);
    exp_t e;
    e.result = res;
    e.flags  = {ovf, co, neg, z};
    e.dest   = dst;
    e.exc    = trap && ovf;
    e.rw     = rw && !e.exc && (dst != 5'd0);
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
`ifdef STATUS_REG_EN
    status_clr = 1'b0;
`endif
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
`ifdef STATUS_REG_EN
    status_clr = 1'b0;
`endif
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    tick(); tick();
    n_tests++;
    if ({out_valid, in_ready, out_result, out_flags, out_dest, out_reg_write, out_exc} !==
        {1'b0, 1'b1, 32'h0, 4'h0, 5'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b rdy=%b res=%h fl=%b d=%0d rw=%b exc=%b required v=0 rdy=1 rest 0",
               out_valid, in_ready, out_result, out_flags, out_dest, out_reg_write, out_exc);
    end
`ifdef STATUS_REG_EN
    n_tests++;
    if (status !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 00000", status);
    end
`endif
    rst = 1'b0;
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    offer(1, 32'h5, 0, 0, 0, 0, 0, 5'd3, 1);
    tick();
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    n_tests++;
    if ({out_valid, out_result, out_dest, out_reg_write, out_flags, out_exc} !==
        {1'b1, 32'h5, 5'd3, 1'b1, 4'b0000, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_head: got v=%b res=%h d=%0d rw=%b fl=%b exc=%b required v=1 res=5 d=3 rw=1 fl=0000 exc=0",
               out_valid, out_result, out_dest, out_reg_write, out_flags, out_exc);
    end
    $display("[TB] basic delivered res=%h dest=%0d", out_result, out_dest);
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    offer(1, 32'h11, 0, 0, 0, 0, 0, 5'd1, 1); tick();
    offer(1, 32'h22, 0, 0, 0, 0, 0, 5'd2, 1); tick();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_in_ready: got %b required 0", in_ready);
    end
    offer(1, 32'h33, 0, 0, 0, 0, 0, 5'd3, 1); tick();
    n_tests++;
    if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 32'h11}) begin
      n_fail++;
      $display("FAIL full_hold: got rdy=%b v=%b res=%h required rdy=0 v=1 res=11", in_ready, out_valid, out_result);
    end
    out_ready = 1'b1;
    tick();
    $display("[TB] delivered 11, head now %h", out_result);
    n_tests++;
    if ({in_ready, out_valid, out_result} !== {1'b1, 1'b1, 32'h22}) begin
      n_fail++;
      $display("FAIL promote: got rdy=%b v=%b res=%h required rdy=1 v=1 res=22", in_ready, out_valid, out_result);
    end
    tick();
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    $display("[TB] delivered 22, head now %h", out_result);
    n_tests++;
    if ({out_valid, out_result, out_dest} !== {1'b1, 32'h33, 5'd3}) begin
      n_fail++;
      $display("FAIL third_entry: got v=%b res=%h d=%0d required v=1 res=33 d=3", out_valid, out_result, out_dest);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    offer(1, 32'h8000_0000, 1, 0, 1, 0, 1, 5'd7, 1); tick();
    offer(1, 32'h8000_0000, 1, 0, 1, 0, 0, 5'd7, 1);
    n_tests++;
    if ({out_exc, out_reg_write, out_flags, out_result} !== {1'b1, 1'b0, 4'b1010, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL ovf_trap: got exc=%b rw=%b fl=%b res=%h required exc=1 rw=0 fl=1010 res=80000000",
               out_exc, out_reg_write, out_flags, out_result);
    end
    $display("[TB] trapped overflow exc=%b", out_exc);
    tick();
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    n_tests++;
    if ({out_valid, out_exc, out_reg_write, out_flags} !== {1'b1, 1'b0, 1'b1, 4'b1010}) begin
      n_fail++;
      $display("FAIL ovf_notrap: got v=%b exc=%b rw=%b fl=%b required v=1 exc=0 rw=1 fl=1010",
               out_valid, out_exc, out_reg_write, out_flags);
    end
    $display("[TB] untrapped overflow exc=%b", out_exc);
    tick();
  endtask

  task automatic test_r0();
    out_ready = 1'b1;
    offer(1, 32'h0, 0, 0, 0, 1, 0, 5'd0, 1); tick();
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    n_tests++;
    if ({out_valid, out_reg_write, out_flags, out_exc} !== {1'b1, 1'b0, 4'b0001, 1'b0}) begin
      n_fail++;
      $display("FAIL r0_write: got v=%b rw=%b fl=%b exc=%b required v=1 rw=0 fl=0001 exc=0",
               out_valid, out_reg_write, out_flags, out_exc);
    end
    $display("[TB] r0 write suppressed rw=%b", out_reg_write);
    tick();
  endtask

  task automatic test_flush();
    bit seen_bad;
    out_ready = 1'b0;
    offer(1, 32'hA1, 0, 0, 0, 0, 0, 5'd4, 1); tick();
    offer(1, 32'hA2, 0, 0, 0, 0, 0, 5'd5, 1); tick();
    offer(1, 32'hBAD, 0, 0, 0, 0, 0, 5'd6, 1);
    flush = 1'b1; tick();
    flush = 1'b0;
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    // Flush while accepting from EMPTY: the offered entry must be dropped.
    offer(1, 32'hBAD, 0, 0, 0, 0, 0, 5'd6, 1);
    flush = 1'b1; tick();
    flush = 1'b0;
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    out_ready = 1'b1;
    seen_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen_bad = 1'b1;
      tick();
    end
    n_tests++;
    if (seen_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: got flushed data visible=%b required 0", seen_bad);
    end
    $display("[TB] flush done");
    // Reset in the middle of traffic.
    out_ready = 1'b0;
    offer(1, 32'hC1, 1, 1, 1, 0, 1, 5'd9, 1); tick();
    offer(1, 32'hC2, 0, 1, 0, 0, 0, 5'd8, 1); tick();
    rst = 1'b1;
    offer(1, 32'hC3, 0, 0, 0, 0, 0, 5'd2, 1); tick();
    rst = 1'b0;
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    n_tests++;
    if ({out_valid, in_ready, out_result, out_flags, out_dest, out_reg_write, out_exc} !==
        {1'b0, 1'b1, 32'h0, 4'h0, 5'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset: got v=%b rdy=%b res=%h fl=%b d=%0d rw=%b exc=%b required v=0 rdy=1 rest 0",
               out_valid, in_ready, out_result, out_flags, out_dest, out_reg_write, out_exc);
    end
    $display("[TB] mid-stream reset done");
  endtask

`ifdef STATUS_REG_EN
  task automatic test_status();
    do_reset();
    out_ready = 1'b1;
    offer(1, 32'h8000_0000, 1, 1, 1, 0, 1, 5'd3, 1); tick();
    offer(1, 32'h0, 0, 0, 0, 1, 0, 5'd4, 1); tick();
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    n_tests++;
    if (status !== 5'b11101) begin
      n_fail++;
      $display("FAIL status_exc: got %b required 11101", status);
    end
    tick();
    n_tests++;
    if (status !== 5'b10011) begin
      n_fail++;
      $display("FAIL status_sticky: got %b required 10011", status);
    end
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    n_tests++;
    if (status !== 5'b00000) begin
      n_fail++;
      $display("FAIL status_clr: got %b required 00000", status);
    end
    offer(1, 32'h1, 1, 0, 0, 0, 1, 5'd3, 1); tick();
    offer(0, 32'h0, 0, 0, 0, 0, 0, 5'd0, 0);
    status_clr = 1'b1; tick(); status_clr = 1'b0;
    n_tests++;
    if (status[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL status_set_wins: got sticky=%b required 1", status[4]);
    end
    $display("[TB] status sticky=%b", status[4]);
  endtask
`endif

  task automatic test_random();
    exp_t        e, head;
    logic        exp_ready, exp_valid, acc, dlv;
    logic [31:0] r;
    logic        ov, co, ng, zr, tr, rw;
    logic [4:0]  d;
    int          n_delivered;
`ifdef STATUS_REG_EN
    logic [4:0]  exp_status;
    exp_status = 5'b0;
`endif
    n_delivered = 0;
    do_reset();
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      exp_ready = (q.size() < 2);
      exp_valid = (q.size() > 0);
      n_tests++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid}) begin
        n_fail++;
        $display("FAIL rand_handshake cyc %0d: got rdy=%b v=%b required rdy=%b v=%b",
                 cyc, in_ready, out_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        head = q[0];
        n_tests++;
        if ({out_result, out_flags, out_dest, out_reg_write, out_exc} !==
            {head.result, head.flags, head.dest, head.rw, head.exc}) begin
          n_fail++;
          $display("FAIL rand_head cyc %0d: got res=%h fl=%b d=%0d rw=%b exc=%b required res=%h fl=%b d=%0d rw=%b exc=%b",
                   cyc, out_result, out_flags, out_dest, out_reg_write, out_exc,
                   head.result, head.flags, head.dest, head.rw, head.exc);
        end
      end
`ifdef STATUS_REG_EN
      n_tests++;
      if (status !== exp_status) begin
        n_fail++;
        $display("FAIL rand_status cyc %0d: got %b required %b", cyc, status, exp_status);
      end
      status_clr = ($urandom_range(0, 99) < 5);
`endif
      r  = $urandom;
      ov = 1'($urandom_range(0, 1)); co = 1'($urandom_range(0, 1));
      ng = 1'($urandom_range(0, 1)); zr = 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      d  = 5'($urandom_range(0, 31));
      offer(($urandom_range(0, 99) < 60), r, ov, co, ng, zr, tr, d, rw);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 2);
      acc = in_valid && exp_ready && !flush;
      dlv = exp_valid && out_ready;
      e   = make_exp(r, ov, co, ng, zr, tr, d, rw);
      tick();
`ifdef STATUS_REG_EN
      if (status_clr) exp_status = 5'b0;
      if (dlv) begin
        exp_status[3:0] = {q[0].flags[2:0], 1'b1};
        if (q[0].exc) exp_status[4] = 1'b1;
      end
`endif
      if (dlv) begin
        void'(q.pop_front());
        n_delivered++;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(e);
    end
    flush = 1'b0;
    in_valid = 1'b0;
`ifdef STATUS_REG_EN
    status_clr = 1'b0;
`endif
    $display("[TB] random run: %0d entries delivered", n_delivered);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_r0();
    test_flush();
`ifdef STATUS_REG_EN
    test_status();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
